// File: rtl/mult_unit.sv
// Sequential 8x8 unsigned shift-and-add multiplier, 16-bit product.
// Optional: define MULT_UNIT_EARLY_TERM_EN to stop once the multiplier runs out of set bits.
module mult_unit (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [7:0] DATA1,
  input  logic [7:0] DATA2,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] RESULT,
  output logic [7:0] RESULT_HI
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      state;
  logic [15:0] mcand;
  logic [7:0]  mplier;
  logic [15:0] acc;
  logic [2:0]  cnt;
  logic [15:0] sum;
  logic        last;

  // Partial-product add for this iteration and the "final iteration" decision
  always_comb begin
    sum = acc;
    if (mplier[0]) begin
      sum = acc + mcand;
    end
`ifdef MULT_UNIT_EARLY_TERM_EN
    last = (cnt == 3'd7) || (mplier[7:1] == 7'd0);
`else
    last = (cnt == 3'd7);
`endif
  end

  // Control FSM with datapath and registered BUSY/DONE/product outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      mcand     <= 16'd0;
      mplier    <= 8'd0;
      acc       <= 16'd0;
      cnt       <= 3'd0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      RESULT    <= 8'd0;
      RESULT_HI <= 8'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            mcand  <= {8'd0, DATA1};
            mplier <= DATA2;
            acc    <= 16'd0;
            cnt    <= 3'd0;
            BUSY   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 3'd1;
          if (last) begin
            RESULT    <= sum[7:0];
            RESULT_HI <= sum[15:8];
            DONE      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed and random multiplies
// against a plain arithmetic reference, plus reset-abort and back-to-back runs.
module tb_mult_unit;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [7:0] DATA1;
  logic [7:0] DATA2;
  logic       BUSY;
  logic       DONE;
  logic [7:0] RESULT;
  logic [7:0] RESULT_HI;

  int errors = 0;
  int checks = 0;

  mult_unit dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .DATA1     (DATA1),
    .DATA2     (DATA2),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .RESULT    (RESULT),
    .RESULT_HI (RESULT_HI)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycles from the START edge to the DONE cycle
  function automatic int exp_lat(input logic [7:0] b);
`ifdef MULT_UNIT_EARLY_TERM_EN
    int hi;
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) hi = i + 1;
    end
    return (hi < 1) ? 1 : hi;
`else
    return (b === 8'hxx) ? 8 : 8;
`endif
  endfunction

  // One operation; scramble keeps START high and changes operands while busy
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input bit scramble, input string tag);
    int lat;
    int busy_n;
    int done_n;
    int done_at;
    logic [15:0] prod;
    prod = 16'(a) * 16'(b);
    lat = exp_lat(b);
    busy_n = 0;
    done_n = 0;
    done_at = -1;
    @(negedge CLK);
    START = 1'b1;
    DATA1 = a;
    DATA2 = b;
    @(posedge CLK);
    #1;
    START = scramble;
    for (int k = 0; k <= lat + 3; k++) begin
      @(negedge CLK);
      if (BUSY) busy_n++;
      if (DONE) begin
        done_n++;
        done_at = k;
      end
      if (scramble) begin
        DATA1 = 8'($urandom);
        DATA2 = 8'($urandom);
        START = (k < lat + 1);
      end
      @(posedge CLK);
    end
    chk({tag, "_done_cnt"}, 32'(done_n), 32'd1);
    chk({tag, "_latency"}, 32'(done_at), 32'(lat));
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(lat + 1));
    #1;
    chk({tag, "_result"}, 32'(RESULT), 32'(prod[7:0]));
    chk({tag, "_result_hi"}, 32'(RESULT_HI), 32'(prod[15:8]));
  endtask

  // START held high: two operations separated by one IDLE cycle
  task automatic back_to_back(input logic [7:0] a, input logic [7:0] b);
    int lat;
    int first_at;
    int second_at;
    logic [15:0] prod;
    prod = 16'(a) * 16'(b);
    lat = exp_lat(b);
    first_at = -1;
    second_at = -1;
    @(negedge CLK);
    START = 1'b1;
    DATA1 = a;
    DATA2 = b;
    @(posedge CLK);
    for (int k = 0; k <= 2 * lat + 3; k++) begin
      @(negedge CLK);
      if (DONE) begin
        if (first_at < 0) first_at = k;
        else if (second_at < 0) second_at = k;
      end
      if (k == 2 * lat + 3) START = 1'b0;
      @(posedge CLK);
    end
    chk("b2b_first_done", 32'(first_at), 32'(lat));
    chk("b2b_second_done", 32'(second_at), 32'(2 * lat + 2));
    #1;
    chk("b2b_result", 32'({RESULT_HI, RESULT}), 32'(prod));
  endtask

  initial begin
    int quiet_busy;
    int quiet_done;
    RESET = 1'b1;
    START = 1'b0;
    DATA1 = 8'h00;
    DATA2 = 8'h00;
    #1;
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_result", 32'(RESULT), 32'd0);
    chk("rst_result_hi", 32'(RESULT_HI), 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    do_op(8'h0C, 8'h05, 1'b0, "c_x_5");
    do_op(8'hFF, 8'hFF, 1'b0, "ff_x_ff");
    do_op(8'h10, 8'h03, 1'b0, "10_x_3");
    do_op(8'hA7, 8'h00, 1'b0, "x_zero");
    do_op(8'h00, 8'hB5, 1'b0, "zero_x");
    do_op(8'h9D, 8'h80, 1'b0, "msb_mult");
    do_op(8'h5A, 8'hC3, 1'b1, "scramble");
    back_to_back(8'h37, 8'h2B);

    for (int i = 0; i < 20; i++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), "rand");
    end

    // Abort mid-run between edges, with START high during reset
    do_op(8'hE1, 8'h9B, 1'b0, "pre_abort");
    @(negedge CLK);
    START = 1'b1;
    DATA1 = 8'h7F;
    DATA2 = 8'hFF;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    chk("abort_result", 32'(RESULT), 32'd0);
    chk("abort_result_hi", 32'(RESULT_HI), 32'd0);
    START = 1'b1;
    @(posedge CLK);
    #1;
    chk("rst_start_ignored", 32'(BUSY), 32'd0);
    @(negedge CLK);
    START = 1'b0;
    RESET = 1'b0;
    quiet_busy = 0;
    quiet_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (BUSY) quiet_busy++;
      if (DONE) quiet_done++;
    end
    chk("abort_no_busy", 32'(quiet_busy), 32'd0);
    chk("abort_no_done", 32'(quiet_done), 32'd0);
    do_op(8'h03, 8'h07, 1'b0, "post_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 Parameters: none; operand width fixed at 8 bits, product width fixed at 16 bits.
REQ-002 CLK  input  1  single clock; all state changes on posedge CLK.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 START  input  1  request a new multiply; sampled on posedge CLK.
REQ-005 DATA1  input  8  multiplicand, unsigned; driven from register-file OUT1.
REQ-006 DATA2  input  8  multiplier, unsigned; driven from register-file OUT2.
REQ-007 BUSY  output  1  high while an operation is in progress (RUN or DONE state).
REQ-008 DONE  output  1  one-cycle pulse; drives register-file WRITE for writeback.
REQ-009 RESULT  output  8  product bits [7:0]; drives register-file IN.
REQ-010 RESULT_HI  output  8  product bits [15:8].

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 In IDLE with START=1 at a posedge, the block SHALL capture DATA1 into a 16-bit multiplicand register (zero-extended), capture DATA2 into an 8-bit multiplier register, clear the 16-bit accumulator and iteration counter, and enter RUN.
REQ-013 In IDLE with START=0, the block SHALL hold all state.
REQ-014 On each RUN posedge, the block SHALL add the multiplicand to the accumulator if multiplier bit 0 is 1, shift the multiplicand left by 1, shift the multiplier right by 1, and increment the counter.
REQ-015 The accumulator SHALL be 16 bits wide; no overflow is possible and no carry-out SHALL be kept.
REQ-016 On the RUN posedge that completes the 8th iteration, the block SHALL load the final accumulator into {RESULT_HI, RESULT} and enter DONE.
REQ-017 In DONE, DONE SHALL be 1 for exactly one cycle, and the next posedge SHALL return the FSM to IDLE unconditionally.
REQ-018 Latency SHALL be as follows: START is sampled at edge 0, DONE is high between edges 8 and 9, and BUSY is high between edges 0 and 9.
REQ-019 START SHALL be ignored while BUSY=1, including in the DONE cycle; DATA1/DATA2 changes during RUN SHALL have no effect.
REQ-020 RESULT and RESULT_HI SHALL change only on entry to DONE and SHALL hold their values through IDLE until the next completion.
REQ-021 BUSY SHALL be a registered output so that the upstream PC stall logic sees a glitch-free signal.

Reset
REQ-022 RESET=1 SHALL immediately, independent of CLK, force IDLE, and set BUSY=0, DONE=0, RESULT=0x00, RESULT_HI=0x00, the accumulator to 0 and the counter to 0.
REQ-023 RESET asserted mid-operation SHALL abort the operation with no DONE pulse; START SHALL be ignored while RESET=1.
REQ-024 After RESET is released, the first posedge with START=1 SHALL begin a new operation normally.

Configuration
REQ-025 Macro MULT_UNIT_EARLY_TERM_EN, when defined, SHALL make a RUN posedge whose shifted multiplier becomes 0 load the product and enter DONE immediately, even if fewer than 8 iterations have run.
REQ-026 With MULT_UNIT_EARLY_TERM_EN defined, latency from the START edge to DONE SHALL be max(1, index of highest set bit of DATA2 + 1) cycles; DATA2=0 SHALL give DONE one cycle after the START edge.
REQ-027 With MULT_UNIT_EARLY_TERM_EN undefined, the block SHALL always run 8 iterations.
REQ-028 Product values SHALL be identical with and without MULT_UNIT_EARLY_TERM_EN.

Verification
REQ-029 DATA1=0x0C, DATA2=0x05, START pulse -> DONE 8 cycles after the START edge, RESULT=0x3C, RESULT_HI=0x00, BUSY high for 9 cycles.
REQ-030 DATA1=0xFF, DATA2=0xFF -> RESULT=0x01, RESULT_HI=0xFE.
REQ-031 START held high continuously -> back-to-back operations with one IDLE cycle between DONE pulses; START during BUSY ignored; DATA2 changed mid-RUN -> product unchanged.
REQ-032 RESET asserted between clock edges at iteration 4 -> BUSY=0, RESULT=0x00 immediately; no DONE pulse; next operation 0x03*0x07 -> RESULT=0x15.
REQ-033 MULT_UNIT_EARLY_TERM_EN defined -> DATA2=0x00 gives DONE 1 cycle after START with RESULT=0x00; DATA1=0x10, DATA2=0x03 gives DONE 2 cycles after START with RESULT=0x30; DATA2=0x80 gives 8 cycles.
